// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a multi-digit common-anode 7-segment display.
// Frame-synchronous display updates via a valid/ready port, with guard intervals, leading-zero blanking and decimal points.

// BCD nibble to active-low segment pattern (bit 7 = DP off, bits 6:0 = g..a); non-BCD codes give all segments off.
module bcd_to_cathode (
    input  logic [3:0] bcd,
    output logic [7:0] seg_c
);
    always_comb begin
        seg_c = 8'hFF;
        case (bcd)
            4'd0:    seg_c = 8'hC0;
            4'd1:    seg_c = 8'hF9;
            4'd2:    seg_c = 8'hA4;
            4'd3:    seg_c = 8'hB0;
            4'd4:    seg_c = 8'h99;
            4'd5:    seg_c = 8'h92;
            4'd6:    seg_c = 8'h82;
            4'd7:    seg_c = 8'hF8;
            4'd8:    seg_c = 8'h80;
            4'd9:    seg_c = 8'h90;
            default: seg_c = 8'hFF;
        endcase
    end
endmodule

module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic [3:0]              digit
);
    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   scan_c;

    logic [CW-1:0] cnt;
    logic [SW-1:0] slot;
    logic          slot_end_c;
    logic          frame_end_c;

    logic [DW-1:0] disp;
    logic [DW-1:0] pend;
    logic          pend_v;
    logic          accept_c;
    logic          xfer_c;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [3:0]            cur_nib;
    logic [7:0]            dec_seg;
    logic                  blank_c;
    logic                  guard_c;

    logic [NUM_DIGITS-1:0] anode_nxt;
    logic [7:0]            cathode_nxt;
    logic [3:0]            digit_nxt;

    // State register: holds the mode of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; enable takes effect in the same cycle so the display darkens on the next edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = SCAN;
            SCAN:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign scan_c      = (state_nxt == SCAN);
    assign slot_end_c  = (cnt == CNT_LAST);
    assign frame_end_c = scan_c & slot_end_c & (slot == SLOT_LAST);

    // Slot and cycle counters; both held at zero while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            slot <= '0;
        end else if (!scan_c) begin
            cnt  <= '0;
            slot <= '0;
        end else if (slot_end_c) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

    // Pending word moves to the display only at a frame boundary or while idle, so no frame mixes words.
    assign accept_c = load_valid & ~pend_v;
    assign xfer_c   = pend_v & (frame_end_c | ~scan_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp       <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            load_ready <= 1'b1;
        end else if (xfer_c) begin
            disp       <= pend;
            pend_v     <= 1'b0;
            load_ready <= 1'b1;
        end else if (accept_c) begin
            pend       <= load_data;
            pend_v     <= 1'b1;
            load_ready <= 1'b0;
        end
    end

    // upper_zero[i] is set when digit i and every digit to its left hold zero.
    always_comb begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib[i] = disp[4*i +: 4];
        end
        upper_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'd0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] & (nib[i] == 4'd0);
        end
    end

    assign cur_nib = nib[slot];

    bcd_to_cathode u_dec (
        .bcd   (cur_nib),
        .seg_c (dec_seg)
    );

    assign blank_c = (cur_nib > 4'd9) | (blank_lz & (slot != '0) & upper_zero[slot]);
    assign guard_c = (cnt < CW'(GUARD));

    // Output logic: next values for the registered pin drivers.
    always_comb begin
        anode_nxt   = '1;
        cathode_nxt = 8'hFF;
        digit_nxt   = 4'h0;
        if (scan_c) begin
            digit_nxt = cur_nib;
            if (!guard_c) begin
                anode_nxt = ~(NUM_DIGITS'(1) << slot);
            end
            if (!blank_c) begin
                cathode_nxt = {~dp_mask[slot], dec_seg[6:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode   <= '1;
            cathode <= 8'hFF;
            digit   <= 4'h0;
        end else begin
            anode   <= anode_nxt;
            cathode <= cathode_nxt;
            digit   <= digit_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a frame-position reference model.
module tb_seven_seg_scan_ctrl;
    localparam int unsigned ND = 8;
    localparam int unsigned RD = 8;
    localparam int unsigned GD = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  anode;
    logic [7:0]  cathode;
    logic [3:0]  digit;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .anode      (anode),
        .cathode    (cathode),
        .digit      (digit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within the frame plus display/pending words.
    int          m_pos;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    bit          m_pend_v;
    logic [7:0]  e_anode;
    logic [7:0]  e_cath;
    logic [3:0]  e_digit;
    logic        e_ready;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] exp_lz  [8]  = '{8'h92, 8'hC0, 8'hF8, 8'hFF,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int s;
        int c;
        logic [3:0] n;
        bit blank;
        bit xfer;
        bit accept;
        if (rst) begin
            m_pos = 0; m_disp = '0; m_pend = '0; m_pend_v = 0;
            e_anode = 8'hFF; e_cath = 8'hFF; e_digit = 4'h0; e_ready = 1'b1;
        end else begin
            if (!enable) begin
                e_anode = 8'hFF; e_cath = 8'hFF; e_digit = 4'h0;
            end else begin
                s = m_pos / RD;
                c = m_pos % RD;
                n = 4'(m_disp >> (4 * s));
                e_digit = n;
                e_anode = (c < int'(GD)) ? 8'hFF : ~(8'(1) << s);
                blank = (n > 4'd9) || (blank_lz && s != 0 && (m_disp >> (4 * s)) == 32'd0);
                if (blank) e_cath = 8'hFF;
                else       e_cath = {~dp_mask[s], seg_tab[n][6:0]};
            end
            xfer   = m_pend_v && (!enable || m_pos == FRAME - 1);
            accept = load_valid && !m_pend_v;
            if (xfer) begin
                m_disp = m_pend; m_pend_v = 0;
            end else if (accept) begin
                m_pend = load_data; m_pend_v = 1;
            end
            m_pos   = enable ? (m_pos + 1) % FRAME : 0;
            e_ready = !m_pend_v;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("anode", 32'(anode), 32'(e_anode));
        chk("cathode", 32'(cathode), 32'(e_cath));
        chk("digit", 32'(digit), 32'(e_digit));
        chk("load_ready", 32'(load_ready), 32'(e_ready));
    endtask

    task automatic run_to(input int p);
        int k = 0;
        while (m_pos != p && k < 3 * FRAME) begin
            step();
            k++;
        end
        chk("run_to", 32'(m_pos), 32'(p));
    endtask

    task automatic wait_disp(input logic [31:0] v);
        int k = 0;
        while (m_disp !== v && k < 3 * FRAME) begin
            step();
            k++;
        end
        chk("wait_disp", m_disp, v);
    endtask

    task automatic do_load(input logic [31:0] v);
        int k = 0;
        while (m_pend_v && k < 3 * FRAME) begin
            step();
            k++;
        end
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        int k;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 4)       w[4*i +: 4] = 4'd0;
            else if (r < 14) w[4*i +: 4] = 4'($urandom_range(0, 9));
            else             w[4*i +: 4] = 4'($urandom_range(10, 15));
        end
        if ($urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(1, 8));
            w = w & (32'hFFFF_FFFF >> (4 * k));
        end
        return w;
    endfunction

    initial begin
        int k;
        rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0;
        blank_lz = 1'b0; dp_mask = '0;
        step();
        step();
        chk("rst_anode", 32'(anode), 32'h0000_00FF);
        chk("rst_cathode", 32'(cathode), 32'h0000_00FF);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);

        // Basic load and scan.
        rst = 1'b0; enable = 1'b1;
        load_valid = 1'b1; load_data = 32'h8765_4321;
        step();
        load_valid = 1'b0;
        chk("ready_drop", 32'(load_ready), 32'h0);
        wait_disp(32'h8765_4321);
        run_to(1);
        chk("guard0_anode", 32'(anode), 32'hFF);
        step();
        chk("guard1_anode", 32'(anode), 32'hFF);
        step();
        chk("slot0_anode", 32'(anode), 32'hFE);
        chk("slot0_cathode", 32'(cathode), 32'hF9);
        run_to(3 * RD + 1);
        chk("slot3_guard", 32'(anode), 32'hFF);
        run_to(3 * RD + GD + 1);
        chk("slot3_anode", 32'(anode), 32'hF7);
        chk("slot3_cathode", 32'(cathode), 32'h99);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(32'h0000_0705);
        wait_disp(32'h0000_0705);
        for (int s = 0; s < 8; s++) begin
            run_to(s * RD + GD + 1);
            chk("lz_cathode", 32'(cathode), 32'(exp_lz[s]));
            chk("lz_digit", 32'(digit), (32'h705 >> (4 * s)) & 32'hF);
        end
        do_load(32'h0);
        wait_disp(32'h0);
        for (int s = 0; s < 8; s++) begin
            run_to(s * RD + GD + 1);
            chk("zero_cathode", 32'(cathode), (s == 0) ? 32'hC0 : 32'hFF);
        end

        // Non-BCD nibble and decimal point.
        blank_lz = 1'b0; dp_mask = 8'h01;
        do_load(32'h00A0_0003);
        wait_disp(32'h00A0_0003);
        run_to(GD + 1);
        chk("dp_cathode", 32'(cathode), 32'h30);
        run_to(5 * RD + GD + 1);
        chk("hex_cathode", 32'(cathode), 32'hFF);
        chk("hex_anode", 32'(anode), 32'hDF);
        dp_mask = 8'h00;

        // Load offered exactly on the boundary cycle; a second word waits.
        run_to(FRAME - 1);
        load_valid = 1'b1; load_data = 32'h1357_2468;
        step();
        chk("bnd_ready", 32'(load_ready), 32'h0);
        load_data = 32'h2468_1357;
        k = 0;
        while (load_ready !== 1'b1 && k < 2 * FRAME) begin
            step();
            k++;
        end
        load_valid = 1'b0;
        chk("bnd_hold", 32'(k), 32'(FRAME));
        run_to(GD + 1);
        chk("bnd_digit", 32'(digit), 32'h8);
        chk("bnd_cathode", 32'(cathode), 32'h80);

        // Reset mid-slot with a pending word.
        run_to(4 * RD);
        do_load(32'h9999_9999);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_anode", 32'(anode), 32'hFF);
        chk("mid_rst_cathode", 32'(cathode), 32'hFF);
        chk("mid_rst_ready", 32'(load_ready), 32'h1);
        run_to(4 * RD + GD + 1);
        chk("rst_slot4_digit", 32'(digit), 32'h0);
        run_to(FRAME - 1);
        step();
        run_to(4 * RD + GD + 1);
        chk("rst_slot4_digit2", 32'(digit), 32'h0);
        chk("rst_slot4_cathode", 32'(cathode), 32'hC0);

        // Enable dropped mid-slot, then re-enabled.
        run_to(2 * RD + 4);
        enable = 1'b0;
        step();
        chk("dis_anode", 32'(anode), 32'hFF);
        chk("dis_cathode", 32'(cathode), 32'hFF);
        step();
        enable = 1'b1;
        k = 0;
        while (anode === 8'hFF && k < 4 * int'(RD)) begin
            step();
            k++;
        end
        chk("first_visible", 32'(k), 32'(GD + 1));

        // Randomized traffic against the model.
        blank_lz = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 99) != 0);
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = rand_word();
            if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 63) == 0) dp_mask  = 8'($urandom);
            step();
        end
        rst = 1'b0; load_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
